// File: rtl/debug_unit.sv
// Host-side debug controller: decodes UART command bytes to load instruction memory,
// run/step/halt the core through its stall input, and report the PC or status bytes.
module debug_unit #(
   parameter int unsigned     SIZE        = 32,
   parameter int unsigned     IMEM_ADDR_W = 10,
   parameter logic [SIZE-1:0] HALT_WORD   = {SIZE{1'b1}}
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [7:0]             i_rx_data,
   input  logic                   i_rx_valid,
   input  logic                   i_tx_busy,
   input  logic [SIZE-1:0]        i_pc,
   input  logic [SIZE-1:0]        i_instruction,
   output logic [7:0]             o_tx_data,
   output logic                   o_tx_start,
   output logic                   o_stall,
   output logic                   o_core_rst,
   output logic                   o_imem_we,
   output logic [IMEM_ADDR_W-1:0] o_imem_addr,
   output logic [SIZE-1:0]        o_imem_data
);

   localparam int unsigned TX_W  = 32;
   localparam logic [7:0]  CMD_L = 8'h4C;
   localparam logic [7:0]  CMD_R = 8'h52;
   localparam logic [7:0]  CMD_S = 8'h53;
   localparam logic [7:0]  CMD_P = 8'h50;
   localparam logic [7:0]  CMD_X = 8'h58;
   localparam logic [TX_W-1:0] ACK_K_BUF  = {8'h4B, 24'h0};
   localparam logic [TX_W-1:0] HALT_H_BUF = {8'h48, 24'h0};

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD_CNT, S_LOAD_DATA, S_RUN, S_STEP, S_SEND
   } state_t;

   typedef enum logic [1:0] {TX_REQ, TX_GAP, TX_WAIT} tx_state_t;

   state_t                 state_q, state_d;
   tx_state_t              tx_state_q, tx_state_d;
   logic [TX_W-1:0]        tx_buf_q, tx_buf_d;
   logic [1:0]             tx_left_q, tx_left_d;
   logic [SIZE-1:0]        word_q, word_d;
   logic [1:0]             byte_cnt_q, byte_cnt_d;
   logic [7:0]             words_left_q, words_left_d;
   logic [IMEM_ADDR_W-1:0] widx_q, widx_d;
   logic                   stall_q, stall_d;
   logic                   core_rst_q, core_rst_d;
   logic                   tx_start_q, tx_start_d;
   logic [7:0]             tx_data_q, tx_data_d;
   logic                   imem_we_q, imem_we_d;
   logic [IMEM_ADDR_W-1:0] imem_addr_q, imem_addr_d;
   logic [SIZE-1:0]        imem_data_q, imem_data_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         tx_state_q   <= TX_REQ;
         tx_buf_q     <= '0;
         tx_left_q    <= '0;
         word_q       <= '0;
         byte_cnt_q   <= '0;
         words_left_q <= '0;
         widx_q       <= '0;
         stall_q      <= 1'b1;
         core_rst_q   <= 1'b0;
         tx_start_q   <= 1'b0;
         tx_data_q    <= '0;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= '0;
         imem_data_q  <= '0;
      end else begin
         state_q      <= state_d;
         tx_state_q   <= tx_state_d;
         tx_buf_q     <= tx_buf_d;
         tx_left_q    <= tx_left_d;
         word_q       <= word_d;
         byte_cnt_q   <= byte_cnt_d;
         words_left_q <= words_left_d;
         widx_q       <= widx_d;
         stall_q      <= stall_d;
         core_rst_q   <= core_rst_d;
         tx_start_q   <= tx_start_d;
         tx_data_q    <= tx_data_d;
         imem_we_q    <= imem_we_d;
         imem_addr_q  <= imem_addr_d;
         imem_data_q  <= imem_data_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      tx_state_d   = tx_state_q;
      tx_buf_d     = tx_buf_q;
      tx_left_d    = tx_left_q;
      word_d       = word_q;
      byte_cnt_d   = byte_cnt_q;
      words_left_d = words_left_q;
      widx_d       = widx_q;
      stall_d      = 1'b1;
      core_rst_d   = core_rst_q;
      tx_start_d   = 1'b0;
      tx_data_d    = tx_data_q;
      imem_we_d    = 1'b0;
      imem_addr_d  = imem_addr_q;
      imem_data_d  = imem_data_q;

      case (state_q)
         S_IDLE: begin
            if (i_rx_valid) begin
               case (i_rx_data)
                  CMD_L: state_d = S_LOAD_CNT;
                  CMD_R: begin
                     state_d = S_RUN;
                     stall_d = 1'b0;
                  end
                  CMD_S: begin
                     state_d = S_STEP;
                     stall_d = 1'b0;
                  end
                  CMD_P: begin
                     state_d    = S_SEND;
                     tx_state_d = TX_REQ;
                     tx_buf_d   = TX_W'(i_pc);
                     tx_left_d  = 2'd3;
                  end
                  default: ;
               endcase
            end
         end
         S_LOAD_CNT: begin
            if (i_rx_valid) begin
               if (i_rx_data == 8'd0) begin
                  state_d = S_IDLE;
               end else begin
                  state_d      = S_LOAD_DATA;
                  core_rst_d   = 1'b1;
                  widx_d       = '0;
                  byte_cnt_d   = '0;
                  word_d       = '0;
                  words_left_d = i_rx_data;
               end
            end
         end
         S_LOAD_DATA: begin
            // Bytes arrive MSB first; the fourth byte completes and commits the word.
            if (i_rx_valid) begin
               word_d     = {word_q[SIZE-9:0], i_rx_data};
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) begin
                  imem_we_d    = 1'b1;
                  imem_addr_d  = widx_q;
                  imem_data_d  = word_d;
                  widx_d       = widx_q + IMEM_ADDR_W'(1);
                  words_left_d = words_left_q - 8'd1;
                  if (words_left_q == 8'd1) begin
                     state_d    = S_SEND;
                     tx_state_d = TX_REQ;
                     tx_buf_d   = ACK_K_BUF;
                     tx_left_d  = 2'd0;
                  end
               end
            end
         end
         S_RUN: begin
            stall_d = 1'b0;
            if ((i_instruction == HALT_WORD) || (i_rx_valid && (i_rx_data == CMD_X))) begin
               stall_d    = 1'b1;
               state_d    = S_SEND;
               tx_state_d = TX_REQ;
               tx_buf_d   = HALT_H_BUF;
               tx_left_d  = 2'd0;
            end
         end
         S_STEP: begin
            state_d    = S_SEND;
            tx_state_d = TX_REQ;
            tx_buf_d   = ACK_K_BUF;
            tx_left_d  = 2'd0;
         end
         S_SEND: begin
            // Core reset is released once a load hands over to its acknowledge.
            core_rst_d = 1'b0;
            case (tx_state_q)
               TX_REQ: begin
                  if (!i_tx_busy) begin
                     tx_start_d = 1'b1;
                     tx_data_d  = tx_buf_q[TX_W-1 -: 8];
                     tx_state_d = TX_GAP;
                  end
               end
               TX_GAP: tx_state_d = TX_WAIT;
               TX_WAIT: begin
                  if (!i_tx_busy) begin
                     if (tx_left_q == 2'd0) begin
                        state_d    = S_IDLE;
                        tx_state_d = TX_REQ;
                     end else begin
                        tx_left_d  = tx_left_q - 2'd1;
                        tx_buf_d   = tx_buf_q << 8;
                        tx_state_d = TX_REQ;
                     end
                  end
               end
               default: tx_state_d = TX_REQ;
            endcase
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign o_tx_data   = tx_data_q;
   assign o_tx_start  = tx_start_q;
   assign o_stall     = stall_q;
   assign o_core_rst  = core_rst_q;
   assign o_imem_we   = imem_we_q;
   assign o_imem_addr = imem_addr_q;
   assign o_imem_data = imem_data_q;

endmodule

// File: tb/tb_debug_unit.sv
// Self-checking bench for debug_unit: table-driven program load plus directed
// run/step/PC/reset/abort sequences against a simple UART transmitter model.
module tb_debug_unit;

   localparam int unsigned SIZE = 32;
   localparam int unsigned AW   = 10;

   typedef struct {
      logic [7:0]    rx;
      logic          we;
      logic [AW-1:0] addr;
      logic [31:0]   data;
      logic          core_rst;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [7:0]    rx_data = '0;
   logic          rx_valid = 1'b0;
   logic          tx_busy;
   logic [31:0]   pc = '0;
   logic [31:0]   instr = '0;
   logic [7:0]    tx_data;
   logic          tx_start;
   logic          stall;
   logic          core_rst;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_data;

   logic          force_busy = 1'b0;
   int            busy_cnt = 0;
   int            stall_low = 0;
   logic [7:0]    tx_q[$];
   logic [AW-1:0] wa_q[$];
   logic [31:0]   wd_q[$];

   int checks = 0;
   int failures = 0;
   int tx_base = 0;
   int wr_base = 0;
   int s0 = 0;
   vec_t tbl [10];

   always #5 clk = ~clk;

   assign tx_busy = force_busy | (busy_cnt != 0);

   debug_unit dut (
      .clk          (clk),
      .rst          (rst),
      .i_rx_data    (rx_data),
      .i_rx_valid   (rx_valid),
      .i_tx_busy    (tx_busy),
      .i_pc         (pc),
      .i_instruction(instr),
      .o_tx_data    (tx_data),
      .o_tx_start   (tx_start),
      .o_stall      (stall),
      .o_core_rst   (core_rst),
      .o_imem_we    (imem_we),
      .o_imem_addr  (imem_addr),
      .o_imem_data  (imem_data)
   );

   // Transmitter model: busy rises the cycle after a start and stays up 4 cycles.
   always @(posedge clk) begin
      if (tx_start) begin
         tx_q.push_back(tx_data);
         busy_cnt <= 4;
      end else if (busy_cnt != 0) begin
         busy_cnt <= busy_cnt - 1;
      end
      if (imem_we) begin
         wa_q.push_back(imem_addr);
         wd_q.push_back(imem_data);
      end
      if (!stall) stall_low <= stall_low + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic wait_tx(input int n, input string name);
      int t;
      t = 0;
      while ((tx_q.size() - tx_base) < n && t < 500) begin
         @(negedge clk);
         t++;
      end
      check({name, " tx count"}, 32'(tx_q.size() - tx_base), 32'(n));
      t = 0;
      while (tx_busy && t < 100) begin
         @(negedge clk);
         t++;
      end
      repeat (4) @(negedge clk);
   endtask

   initial begin
      tbl[0] = '{8'h4C, 1'b0, 10'd0, 32'h0,        1'b0};
      tbl[1] = '{8'h02, 1'b0, 10'd0, 32'h0,        1'b1};
      tbl[2] = '{8'hDE, 1'b0, 10'd0, 32'h0,        1'b1};
      tbl[3] = '{8'hAD, 1'b0, 10'd0, 32'h0,        1'b1};
      tbl[4] = '{8'hBE, 1'b0, 10'd0, 32'h0,        1'b1};
      tbl[5] = '{8'hEF, 1'b1, 10'd0, 32'hDEADBEEF, 1'b1};
      tbl[6] = '{8'h00, 1'b0, 10'd0, 32'h0,        1'b1};
      tbl[7] = '{8'h00, 1'b0, 10'd0, 32'h0,        1'b1};
      tbl[8] = '{8'h00, 1'b0, 10'd0, 32'h0,        1'b1};
      tbl[9] = '{8'h01, 1'b1, 10'd1, 32'h00000001, 1'b1};

      repeat (3) @(negedge clk);
      check("rst stall",    32'(stall),     32'd1);
      check("rst core_rst", 32'(core_rst),  32'd0);
      check("rst tx_start", 32'(tx_start),  32'd0);
      check("rst tx_data",  32'(tx_data),   32'd0);
      check("rst imem_we",  32'(imem_we),   32'd0);
      check("rst imem_addr",32'(imem_addr), 32'd0);
      check("rst imem_data",imem_data,      32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // T1: table-driven two-word load
      tx_base = tx_q.size();
      wr_base = wa_q.size();
      for (int i = 0; i < 10; i++) begin
         send_byte(tbl[i].rx);
         check($sformatf("T1[%0d] we", i), 32'(imem_we), 32'(tbl[i].we));
         check($sformatf("T1[%0d] core_rst", i), 32'(core_rst), 32'(tbl[i].core_rst));
         check($sformatf("T1[%0d] stall", i), 32'(stall), 32'd1);
         if (tbl[i].we) begin
            check($sformatf("T1[%0d] addr", i), 32'(imem_addr), 32'(tbl[i].addr));
            check($sformatf("T1[%0d] data", i), imem_data, tbl[i].data);
         end
      end
      wait_tx(1, "T1");
      check("T1 ack", 32'(tx_q[tx_base]), 32'h4B);
      check("T1 writes", 32'(wa_q.size() - wr_base), 32'd2);
      check("T1 core_rst after", 32'(core_rst), 32'd0);

      // Zero-length load: no writes, no ack
      tx_base = tx_q.size();
      wr_base = wa_q.size();
      send_byte(8'h4C);
      send_byte(8'h00);
      repeat (20) @(negedge clk);
      check("N0 tx", 32'(tx_q.size() - tx_base), 32'd0);
      check("N0 writes", 32'(wa_q.size() - wr_base), 32'd0);
      check("N0 core_rst", 32'(core_rst), 32'd0);

      // T2: run until halt word fetched in cycle 5
      tx_base = tx_q.size();
      s0 = stall_low;
      send_byte(8'h52);
      for (int c = 1; c <= 5; c++) begin
         if (c == 5) instr = 32'hFFFFFFFF;
         check($sformatf("T2 stall c%0d", c), 32'(stall), 32'd0);
         @(negedge clk);
      end
      instr = '0;
      check("T2 stall c6", 32'(stall), 32'd1);
      wait_tx(1, "T2");
      check("T2 halt byte", 32'(tx_q[tx_base]), 32'h48);
      check("T2 low cycles", 32'(stall_low - s0), 32'd5);

      // T3: three single steps
      for (int k = 0; k < 3; k++) begin
         tx_base = tx_q.size();
         s0 = stall_low;
         send_byte(8'h53);
         check($sformatf("T3[%0d] stall low", k), 32'(stall), 32'd0);
         @(negedge clk);
         check($sformatf("T3[%0d] stall back", k), 32'(stall), 32'd1);
         wait_tx(1, "T3");
         check($sformatf("T3[%0d] ack", k), 32'(tx_q[tx_base]), 32'h4B);
         check($sformatf("T3[%0d] low cycles", k), 32'(stall_low - s0), 32'd1);
      end

      // T4: PC readback, first start held off by a busy transmitter
      tx_base = tx_q.size();
      pc = 32'h00000123;
      force_busy = 1'b1;
      send_byte(8'h50);
      pc = 32'hFFFFFFFF;
      repeat (10) @(negedge clk);
      check("T4 held tx", 32'(tx_q.size() - tx_base), 32'd0);
      check("T4 held start", 32'(tx_start), 32'd0);
      force_busy = 1'b0;
      wait_tx(4, "T4");
      check("T4 byte0", 32'(tx_q[tx_base]),     32'h00);
      check("T4 byte1", 32'(tx_q[tx_base + 1]), 32'h00);
      check("T4 byte2", 32'(tx_q[tx_base + 2]), 32'h01);
      check("T4 byte3", 32'(tx_q[tx_base + 3]), 32'h23);

      // T5: reset mid-load discards the partial word
      tx_base = tx_q.size();
      wr_base = wa_q.size();
      send_byte(8'h4C);
      send_byte(8'h01);
      send_byte(8'hAA);
      send_byte(8'hBB);
      check("T5 core_rst mid", 32'(core_rst), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("T5 core_rst in rst", 32'(core_rst), 32'd0);
      check("T5 stall in rst", 32'(stall), 32'd1);
      rst = 1'b0;
      @(negedge clk);
      send_byte(8'h4C);
      send_byte(8'h01);
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33);
      send_byte(8'h44);
      wait_tx(1, "T5");
      check("T5 writes", 32'(wa_q.size() - wr_base), 32'd1);
      if (wa_q.size() > wr_base) begin
         check("T5 addr", 32'(wa_q[wr_base]), 32'd0);
         check("T5 data", wd_q[wr_base], 32'h11223344);
      end
      check("T5 ack", 32'(tx_q[tx_base]), 32'h4B);

      // T6: run aborted by 'X'; other bytes ignored while running
      tx_base = tx_q.size();
      wr_base = wa_q.size();
      send_byte(8'h52);
      repeat (3) @(negedge clk);
      send_byte(8'h51);
      check("T6 stall after Q", 32'(stall), 32'd0);
      send_byte(8'h4C);
      check("T6 stall after L", 32'(stall), 32'd0);
      repeat (3) @(negedge clk);
      check("T6 no tx", 32'(tx_q.size() - tx_base), 32'd0);
      send_byte(8'h58);
      check("T6 stall after X", 32'(stall), 32'd1);
      wait_tx(1, "T6");
      check("T6 halt byte", 32'(tx_q[tx_base]), 32'h48);
      check("T6 writes", 32'(wa_q.size() - wr_base), 32'd0);
      check("T6 core_rst", 32'(core_rst), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
